// File: rtl/seq_divide_16_if.sv
// seq_divide_16_if: start/done handshake and operand/result bundle
// shared by the ALU controller (master) and the divider (slave).
interface seq_divide_16_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );
endinterface

// File: rtl/seq_divide_16.sv
// seq_divide_16: restoring unsigned divider, one quotient bit per clock.
// SEQ_DIV_DBZ_FAST_EN: a zero divisor completes at acceptance.
module seq_divide_16 #(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  seq_divide_16_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] d_nxt;
  logic [WIDTH:0]   r;
  logic [WIDTH:0]   r_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             dbz;
  logic             dbz_nxt;

  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] rem_nxt;
  logic             dz;
  logic             dz_nxt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             last;

  assign shifted = {r[WIDTH-1:0], q[WIDTH-1]};
  assign trial   = shifted - {1'b0, d};
  assign last    = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      q     <= '0;
      d     <= '0;
      r     <= '0;
      cnt   <= '0;
      dbz   <= 1'b0;
      quo   <= '0;
      rem   <= '0;
      dz    <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      d     <= d_nxt;
      r     <= r_nxt;
      cnt   <= cnt_nxt;
      dbz   <= dbz_nxt;
      quo   <= quo_nxt;
      rem   <= rem_nxt;
      dz    <= dz_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    d_nxt     = d;
    r_nxt     = r;
    cnt_nxt   = cnt;
    dbz_nxt   = dbz;
    quo_nxt   = quo;
    rem_nxt   = rem;
    dz_nxt    = dz;

    unique case (state)
      IDLE, DONE: begin
        if (state == DONE) begin
          state_nxt = IDLE;
        end
        if (bus.start) begin
          state_nxt = RUN;
          q_nxt     = bus.dividend;
          d_nxt     = bus.divisor;
          r_nxt     = '0;
          cnt_nxt   = CW'(WIDTH);
          dbz_nxt   = (bus.divisor == '0);
`ifdef SEQ_DIV_DBZ_FAST_EN
          if (bus.divisor == '0) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
            quo_nxt   = '1;
            rem_nxt   = bus.dividend;
            dz_nxt    = 1'b1;
          end
`else
`endif
        end
      end
      RUN: begin
        // trial MSB set means the subtraction borrowed: restore
        if (!trial[WIDTH]) begin
          r_nxt = trial;
          q_nxt = {q[WIDTH-2:0], 1'b1};
        end else begin
          r_nxt = shifted;
          q_nxt = {q[WIDTH-2:0], 1'b0};
        end
        cnt_nxt = cnt - CW'(1);
        if (last) begin
          state_nxt = DONE;
          quo_nxt   = q_nxt;
          rem_nxt   = r_nxt[WIDTH-1:0];
          dz_nxt    = dbz;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quo;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dz;
endmodule

// File: tb/tb_seq_divide_16.sv
// tb_seq_divide_16: directed self-checking bench for seq_divide_16.
// Honors SEQ_DIV_DBZ_FAST_EN for the zero-divisor latency.
module tb_seq_divide_16;
  localparam int W = 16;
`ifdef SEQ_DIV_DBZ_FAST_EN
  localparam int DBZ_LAT  = 0;
  localparam int DBZ_BUSY = 0;
`else
  localparam int DBZ_LAT  = W;
  localparam int DBZ_BUSY = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  seq_divide_16_if #(.WIDTH(W)) bus ();

  seq_divide_16 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int edges, output int busy_n);
    edges  = 0;
    busy_n = 0;
    while (bus.done !== 1'b1 && edges < 40) begin
      if (bus.busy === 1'b1) busy_n++;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] dvd,
                        input logic [W-1:0] dvs, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input logic ez,
                        input int elat, input int ebusy);
    int edges;
    int busy_n;
    issue(dvd, dvs);
    bus.start = 1'b0;
    wait_done(edges, busy_n);
    chk({tag, "_lat"}, edges, elat);
    chk({tag, "_busy_cycles"}, busy_n, ebusy);
    chk({tag, "_quo"}, bus.quotient, eq);
    chk({tag, "_rem"}, bus.remainder, er);
    chk({tag, "_dbz"}, bus.div_by_zero, ez);
    chk({tag, "_busy_in_done"}, bus.busy, 1'b0);
    @(posedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, bus.done, 1'b0);
  endtask

  initial begin
    int edges;
    int busy_n;
    int seen;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    #12;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_quo", bus.quotient, 0);
    chk("rst_rem", bus.remainder, 0);
    chk("rst_dbz", bus.div_by_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_op("d1000_7", 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0, W, W);
    run_op("dffff_1", 16'hffff, 16'd1, 16'hffff, 16'd0, 1'b0, W, W);
    run_op("d5_10", 16'd5, 16'd10, 16'd0, 16'd5, 1'b0, W, W);
    run_op("d1234_0", 16'h1234, 16'd0, 16'hffff, 16'h1234, 1'b1,
           DBZ_LAT, DBZ_BUSY);

    // start held high through RUN while operands wander
    issue(16'd1000, 16'd7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.dividend = 16'(i * 111 + 3);
      bus.divisor  = 16'(i + 2);
    end
    wait_done(edges, busy_n);
    bus.start = 1'b0;
    chk("hold_done", bus.done, 1'b1);
    chk("hold_quo", bus.quotient, 142);
    chk("hold_rem", bus.remainder, 6);
    @(posedge clk);
    #1;
    chk("hold_no_second_busy", bus.busy, 1'b0);
    chk("hold_no_second_done", bus.done, 1'b0);

    // back-to-back: second start during the done cycle
    issue(16'd100, 16'd3);
    bus.start = 1'b0;
    wait_done(edges, busy_n);
    chk("b2b1_lat", edges, W);
    chk("b2b1_quo", bus.quotient, 33);
    chk("b2b1_rem", bus.remainder, 1);
    bus.start    = 1'b1;
    bus.dividend = 16'd81;
    bus.divisor  = 16'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b2_accept_busy", bus.busy, 1'b1);
    chk("b2b2_accept_done", bus.done, 1'b0);
    chk("b2b_hold_quo", bus.quotient, 33);
    chk("b2b_hold_rem", bus.remainder, 1);
    wait_done(edges, busy_n);
    chk("b2b_done_spacing", edges + 1, W + 1);
    chk("b2b2_quo", bus.quotient, 9);
    chk("b2b2_rem", bus.remainder, 0);
    @(posedge clk);
    #1;
    chk("b2b2_done_one_cycle", bus.done, 1'b0);

    // async reset in the middle of an operation
    issue(16'd1000, 16'd7);
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_done", bus.done, 1'b0);
    chk("mid_rst_quo", bus.quotient, 0);
    chk("mid_rst_rem", bus.remainder, 0);
    chk("mid_rst_dbz", bus.div_by_zero, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen++;
    end
    chk("mid_rst_no_done", seen, 0);

    run_op("d50_5", 16'd50, 16'd5, 16'd10, 16'd0, 1'b0, W, W);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
